// File: rtl/fpu_sqrt_round_pkg.sv
// Shared FPU definitions: rounding-mode encodings, fflags bit positions, canonical NaN.
// Pure declarations, no latency or flow control.
package fpu_sqrt_round_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    function automatic logic [4:0] mk_fflags(input logic nv, input logic dz, input logic of,
                                             input logic uf, input logic nx);
        logic [4:0] f;
        f           = 5'd0;
        f[FFLAG_NV] = nv;
        f[FFLAG_DZ] = dz;
        f[FFLAG_OF] = of;
        f[FFLAG_UF] = uf;
        f[FFLAG_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/fpu_sqrt_round_inc.sv
// Round-increment decision from rounding mode and L/G/R/S bits.
// Purely combinational; no flow control.
module fpu_round_inc
    import fpu_sqrt_round_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       L,
    input  logic       G,
    input  logic       R,
    input  logic       S,
    output logic       inc
);

    // Undefined encodings fall through to round-to-nearest-even.
    always_comb begin
        inc = G & (L | R | S);
        case (rm)
            RM_RTZ, RM_RDN: inc = 1'b0;
            RM_RUP:         inc = G | R | S;
            RM_RMM:         inc = G;
            default:        ;
        endcase
    end

endmodule

// File: rtl/fpu_sqrt_round.sv
// Square-root rounding/packing back end: S1 decides increment, S2 rounds, packs and holds output.
// Latency 2 cycles; S2 holds while out_ready=0, in_ready drops when both stages are full.
module fpu_sqrt_round
    import fpu_sqrt_round_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sqrt_done,
    input  logic [26:0] sqrt_proNorm_sig,
    input  logic [7:0]  sqrt_proNorm_exp,
    input  logic        uf,
    input  logic [2:0]  rm,
    input  logic        is_special,
    input  logic [31:0] special_result,
    input  logic        special_nv,
    input  logic        flush,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags,
    output logic        drop_err
);

    logic        r_s1_vld;
    logic [23:0] r_s1_man;
    logic [7:0]  r_s1_exp;
    logic        r_s1_inc;
    logic        r_s1_special;
    logic [31:0] r_s1_spec_res;
    logic [4:0]  r_s1_fflags;

    logic        r_s2_vld;
    logic [31:0] r_s2_result;
    logic [4:0]  r_s2_fflags;
    logic        r_drop_err;

    logic        w_inc;
    logic        w_nx;
    logic        w_cap;
    logic        w_s1_adv;
    logic [24:0] w_sum;
    logic        w_carry;
    logic        w_hidden;
    logic [22:0] w_frac;
    logic [7:0]  w_exp;
    logic [31:0] w_packed;

    fpu_round_inc u_round_inc (
        .rm  (rm),
        .L   (sqrt_proNorm_sig[3]),
        .G   (sqrt_proNorm_sig[2]),
        .R   (sqrt_proNorm_sig[1]),
        .S   (sqrt_proNorm_sig[0]),
        .inc (w_inc)
    );

    assign in_ready = !(r_s1_vld && r_s2_vld);
    assign w_nx     = |sqrt_proNorm_sig[2:0];
    assign w_cap    = sqrt_done && in_ready && !flush;
    assign w_s1_adv = r_s1_vld && (!r_s2_vld || out_ready);

    // A carry out of {hidden,fraction} renormalises to 1.0 x 2^(exp+1).
    assign w_sum    = {1'b0, r_s1_man} + {24'd0, r_s1_inc};
    assign w_carry  = w_sum[24];
    assign w_hidden = w_carry | w_sum[23];
    assign w_frac   = w_carry ? 23'd0 : w_sum[22:0];
    assign w_exp    = w_carry ? (r_s1_exp + 8'd1) : r_s1_exp;
    assign w_packed = {1'b0, (w_hidden ? w_exp : 8'd0), w_frac};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld      <= 1'b0;
            r_s1_man      <= 24'd0;
            r_s1_exp      <= 8'd0;
            r_s1_inc      <= 1'b0;
            r_s1_special  <= 1'b0;
            r_s1_spec_res <= 32'd0;
            r_s1_fflags   <= 5'd0;
        end else if (flush) begin
            r_s1_vld <= 1'b0;
        end else if (w_cap) begin
            r_s1_vld      <= 1'b1;
            r_s1_man      <= sqrt_proNorm_sig[26:3];
            r_s1_exp      <= sqrt_proNorm_exp;
            r_s1_inc      <= w_inc;
            r_s1_special  <= is_special;
            r_s1_spec_res <= special_result;
            r_s1_fflags   <= is_special ? mk_fflags(special_nv, 1'b0, 1'b0, 1'b0, 1'b0)
                                        : mk_fflags(1'b0, 1'b0, 1'b0, uf & w_nx, w_nx);
        end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld    <= 1'b0;
            r_s2_result <= 32'd0;
            r_s2_fflags <= 5'd0;
        end else if (flush) begin
            r_s2_vld <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_vld    <= 1'b1;
            r_s2_result <= r_s1_special ? r_s1_spec_res : w_packed;
            r_s2_fflags <= r_s1_fflags;
        end else if (out_ready) begin
            r_s2_vld <= 1'b0;
        end
    end

    // A pulse coinciding with flush is discarded silently, not counted as an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_err <= 1'b0;
        end else if (sqrt_done && !in_ready && !flush) begin
            r_drop_err <= 1'b1;
        end
    end

    assign out_valid = r_s2_vld;
    assign result    = r_s2_result;
    assign fflags    = r_s2_fflags;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_fpu_sqrt_round.sv
// Bench for fpu_sqrt_round: directed vectors plus random traffic against a
// transaction-level rounding model with an in-order expected-result queue.
module tb_fpu_sqrt_round;
    import fpu_sqrt_round_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sqrt_done;
    logic [26:0] sig;
    logic [7:0]  ex;
    logic        uf;
    logic [2:0]  rm;
    logic        is_special;
    logic [31:0] special_result;
    logic        special_nv;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;
    logic        drop_err;

    fpu_sqrt_round dut (
        .clk(clk), .reset(reset), .sqrt_done(sqrt_done),
        .sqrt_proNorm_sig(sig), .sqrt_proNorm_exp(ex), .uf(uf), .rm(rm),
        .is_special(is_special), .special_result(special_result), .special_nv(special_nv),
        .flush(flush), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .fflags(fflags), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  ff;
        int          stamp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic drop_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Rounding model: integer mantissa plus 3-bit remainder, compared against the halfway point.
    function automatic exp_t model(input logic [26:0] s, input logic [7:0] e, input logic [2:0] m,
                                   input logic u, input logic sp, input logic [31:0] sres,
                                   input logic snv);
        exp_t        t;
        int unsigned man;
        int unsigned rem;
        int unsigned up;
        logic [7:0]  ee;
        logic        nx;
        t.stamp = cyc;
        if (sp) begin
            t.res = sres;
            t.ff  = {snv, 4'b0000};
            return t;
        end
        man = int'(s) >> 3;
        rem = int'(s) & 7;
        case (m)
            3'd1, 3'd2: up = 0;
            3'd3:       up = (rem != 0) ? 1 : 0;
            3'd4:       up = (rem >= 4) ? 1 : 0;
            default:    up = (rem > 4 || (rem == 4 && (man % 2) == 1)) ? 1 : 0;
        endcase
        man = man + up;
        ee  = e;
        if (man == 32'h0100_0000) begin
            man = 32'h0080_0000;
            ee  = e + 8'd1;
        end
        nx    = (rem != 0);
        t.res = {1'b0, (man >= 32'h0080_0000) ? ee : 8'd0, 23'(man)};
        t.ff  = {3'b000, u & nx, nx};
        return t;
    endfunction

    // One clock: check outputs against the model, update the model, advance the clock.
    task automatic tick();
        logic exp_rdy;
        logic exp_ov;
        if (reset) begin
            q.delete();
            drop_m = 1'b0;
        end else begin
            exp_rdy = (q.size() < 2);
            exp_ov  = (q.size() > 0) && (cyc >= q[0].stamp + 2);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov && out_valid) begin
                chk("result", result, q[0].res);
                chk("fflags", {27'd0, fflags}, {27'd0, q[0].ff});
            end
            chk("drop_err", {31'd0, drop_err}, {31'd0, drop_m});
            if (exp_ov && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (sqrt_done) begin
                if (exp_rdy) q.push_back(model(sig, ex, rm, uf, is_special, special_result, special_nv));
                else drop_m = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [26:0] s, input logic [7:0] e, input logic [2:0] m,
                         input logic u, input logic sp, input logic [31:0] sres, input logic snv);
        sig = s; ex = e; rm = m; uf = u;
        is_special = sp; special_result = sres; special_nv = snv;
        sqrt_done = 1'b1;
        tick();
        sqrt_done = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] r, input logic [4:0] f);
        tick();
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, result, r);
        chk({tag, "_ff"}, {27'd0, fflags}, {27'd0, f});
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sqrt_done = 1'b0; sig = '0; ex = '0; uf = 1'b0; rm = 3'd0;
        is_special = 1'b0; special_result = '0; special_nv = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_result", result, 32'd0);
        chk("rst_fflags", {27'd0, fflags}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_drop_err", {31'd0, drop_err}, 32'd0);

        drive(27'h4000000, 8'd128, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("two", 32'h4000_0000, 5'b00000);
        drive(27'h5A82799, 8'd127, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("sqrt2_rne", 32'h3FB5_04F3, 5'b00001);
        drive(27'h5A82799, 8'd127, 3'b011, 1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("sqrt2_rup", 32'h3FB5_04F4, 5'b00001);
        drive(27'h7FFFFFC, 8'd127, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("carry_rne", 32'h4000_0000, 5'b00001);
        drive(27'h7FFFFFC, 8'd127, 3'b001, 1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("carry_rtz", 32'h3FFF_FFFF, 5'b00001);
        drive(27'h7FFFFFC, 8'd127, 3'b111, 1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("rm111_rne", 32'h4000_0000, 5'b00001);
        drive(27'h0000005, 8'd1, 3'b100, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_out("tiny_rmm", 32'h0000_0001, 5'b00011);
        drive(27'h0, 8'd0, 3'b000, 1'b0, 1'b1, CANON_NAN, 1'b1);
        expect_out("special_nan", 32'h7FC0_0000, 5'b10000);

        // Flush with both stages full, then flush colliding with a new pulse.
        out_ready = 1'b0;
        drive(27'h4000000, 8'd100, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(27'h5A82799, 8'd101, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ov", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(27'h4000000, 8'd90, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("flushcol_ov", {31'd0, out_valid}, 32'd0);
        chk("flushcol_drop", {31'd0, drop_err}, 32'd0);

        // Stall with three back-to-back pulses: third is dropped.
        out_ready = 1'b0;
        drive(27'h4000000, 8'd10, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(27'h4000000, 8'd20, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(27'h4000000, 8'd30, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("stall_drop", {31'd0, drop_err}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_head", result, {1'b0, 8'd10, 23'd0});
        out_ready = 1'b1;
        tick();
        chk("stall_second", result, {1'b0, 8'd20, 23'd0});
        for (int i = 0; i < 3; i++) tick();
        chk("stall_empty", {31'd0, out_valid}, 32'd0);

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            sqrt_done      = ($urandom_range(0, 2) != 0);
            sig            = 27'($urandom);
            ex             = 8'($urandom_range(1, 254));
            rm             = 3'($urandom_range(0, 7));
            uf             = 1'($urandom_range(0, 1));
            is_special     = ($urandom_range(0, 7) == 0);
            special_result = $urandom;
            special_nv     = 1'($urandom_range(0, 1));
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 59) == 0);
            tick();
        end
        sqrt_done = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
